// File: rtl/laser_feeder.sv
// laser_feeder
//   Host-side driver for the two-circle laser placement engine. Buffers
//   ITEM_NUM target points from a loader, pulses the engine reset, streams
//   the points one per cycle on X/Y, waits for the engine's DONE pulse and
//   captures both circle centres. Optionally scores the result by counting
//   the buffered points that fall inside either circle.
//
//   Build option: define LASER_FEEDER_SCORE_EN to build the SCORE state and
//   the coverage datapath. Without it, WAIT goes straight to REPORT and
//   RES_COVER is tied to zero.
//
// Ports
//   CLK, RST                   clock, asynchronous active-low reset
//   LD_VALID/LD_X/LD_Y/LD_READY loader point handshake (IDLE only)
//   CLR, START                 buffer clear / run request (IDLE only)
//   LRST, X, Y                 engine reset and point stream
//   C1X..C2Y, DONE             engine result and its one-cycle valid
//   BUSY                       run in progress
//   RES_VALID, RES_ERR         one-cycle result pulse, timeout flag
//   RES_C1X..RES_C2Y, RES_COVER captured centres and covered-point count
module laser_feeder #(
  parameter int ITEM_NUM    = 40,
  parameter int RADIUS      = 4,
  parameter int ENG_RST_CYC = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD_VALID,
  input  logic [3:0] LD_X,
  input  logic [3:0] LD_Y,
  output logic       LD_READY,
  input  logic       CLR,
  input  logic       START,
  output logic       LRST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE,
  output logic       BUSY,
  output logic       RES_VALID,
  output logic       RES_ERR,
  output logic [3:0] RES_C1X,
  output logic [3:0] RES_C1Y,
  output logic [3:0] RES_C2X,
  output logic [3:0] RES_C2Y,
  output logic [5:0] RES_COVER
);

  typedef enum logic [2:0] {
    S_IDLE, S_ENG_RST, S_STREAM, S_WAIT, S_SCORE, S_REPORT
  } state_e;

  localparam logic [5:0]  ITEM_N   = 6'(ITEM_NUM);
  localparam logic [16:0] RST_LAST = 17'(ENG_RST_CYC - 1);
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYC - 1);

  // Point buffer, {x, y} per entry. Not reset: only count_q gates access.
  logic [7:0] pt_mem [ITEM_NUM];

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [5:0]  idx_q, idx_d;     // stream / score read pointer
  logic [16:0] tmo_q, tmo_d;     // engine-reset length and DONE timeout
  logic        lrst_q, lrst_d;
  logic [3:0]  x_q, x_d, y_q, y_d;
  logic        busy_q, busy_d;
  logic        res_valid_q, res_valid_d;
  logic        res_err_q, res_err_d;
  logic [3:0]  c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;

  logic        wr_en;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_pt;

  assign LD_READY = (state_q == S_IDLE) && (count_q < ITEM_N);
  // CLR beats a simultaneous load, so the colliding point is dropped.
  assign wr_en    = (state_q == S_IDLE) && !CLR && LD_VALID && LD_READY;

  always_ff @(posedge CLK) begin
    if (wr_en) pt_mem[count_q] <= {LD_X, LD_Y};
  end

  // The pointer reaches ITEM_NUM on the last stream/score cycle; clamp it
  // so the (unused) read stays inside the array.
  assign rd_addr = (idx_q < ITEM_N) ? idx_q : 6'd0;
  assign rd_pt   = pt_mem[rd_addr];

`ifdef LASER_FEEDER_SCORE_EN
  localparam logic [8:0] R_SQ = 9'(RADIUS * RADIUS);

  logic [7:0] pt_q, pt_d;        // point under test during SCORE
  logic [5:0] cover_q, cover_d;
  logic       hit;

  // |d|^2 is identical to the square of the 5-bit signed difference.
  function automatic logic covers(input logic [7:0] p, input logic [3:0] cx,
                                  input logic [3:0] cy);
    logic [8:0] ax, ay;
    ax = {5'd0, (p[7:4] >= cx) ? (p[7:4] - cx) : (cx - p[7:4])};
    ay = {5'd0, (p[3:0] >= cy) ? (p[3:0] - cy) : (cy - p[3:0])};
    return (ax * ax + ay * ay) <= R_SQ;
  endfunction

  assign hit       = covers(pt_q, c1x_q, c1y_q) | covers(pt_q, c2x_q, c2y_q);
  assign RES_COVER = cover_q;
`else
  assign RES_COVER = 6'd0;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    lrst_d      = lrst_q;
    x_d         = x_q;
    y_d         = y_q;
    res_valid_d = 1'b0;
    res_err_d   = res_err_q;
    c1x_d       = c1x_q;
    c1y_d       = c1y_q;
    c2x_d       = c2x_q;
    c2y_d       = c2y_q;
`ifdef LASER_FEEDER_SCORE_EN
    pt_d        = pt_q;
    cover_d     = cover_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (CLR) begin
          count_d = 6'd0;
        end else begin
          if (wr_en) count_d = count_q + 6'd1;
          if (START && (count_q == ITEM_N)) begin
            state_d = S_ENG_RST;
            lrst_d  = 1'b1;
            tmo_d   = 17'd0;
            idx_d   = 6'd0;
          end
        end
      end
      S_ENG_RST: begin
        if (tmo_q == RST_LAST) begin
          // Release the engine in the same cycle point 0 appears.
          state_d    = S_STREAM;
          lrst_d     = 1'b0;
          {x_d, y_d} = rd_pt;
          idx_d      = idx_q + 6'd1;
          tmo_d      = 17'd0;
        end else begin
          tmo_d = tmo_q + 17'd1;
        end
      end
      S_STREAM: begin
        if (idx_q == ITEM_N) begin
          state_d = S_WAIT;
          idx_d   = 6'd0;
          x_d     = 4'd0;
          y_d     = 4'd0;
        end else begin
          {x_d, y_d} = rd_pt;
          idx_d      = idx_q + 6'd1;
        end
      end
      S_WAIT: begin
        if (DONE) begin
          c1x_d     = C1X;
          c1y_d     = C1Y;
          c2x_d     = C2X;
          c2y_d     = C2Y;
          res_err_d = 1'b0;
`ifdef LASER_FEEDER_SCORE_EN
          // Prefetch point 0 so scoring takes exactly ITEM_NUM cycles.
          state_d   = S_SCORE;
          cover_d   = 6'd0;
          pt_d      = rd_pt;
          idx_d     = idx_q + 6'd1;
`else
          state_d     = S_REPORT;
          res_valid_d = 1'b1;
`endif
        end else if (tmo_q == TMO_LAST) begin
          state_d     = S_REPORT;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          lrst_d      = 1'b1;
`ifdef LASER_FEEDER_SCORE_EN
          cover_d     = 6'd0;
`endif
        end else begin
          tmo_d = tmo_q + 17'd1;
        end
      end
`ifdef LASER_FEEDER_SCORE_EN
      S_SCORE: begin
        cover_d = cover_q + {5'd0, hit};
        if (idx_q == ITEM_N) begin
          state_d     = S_REPORT;
          res_valid_d = 1'b1;
          idx_d       = 6'd0;
        end else begin
          pt_d  = rd_pt;
          idx_d = idx_q + 6'd1;
        end
      end
`endif
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      count_q     <= 6'd0;
      idx_q       <= 6'd0;
      tmo_q       <= 17'd0;
      lrst_q      <= 1'b1;
      x_q         <= 4'd0;
      y_q         <= 4'd0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      c1x_q       <= 4'd0;
      c1y_q       <= 4'd0;
      c2x_q       <= 4'd0;
      c2y_q       <= 4'd0;
`ifdef LASER_FEEDER_SCORE_EN
      pt_q        <= 8'd0;
      cover_q     <= 6'd0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      lrst_q      <= lrst_d;
      x_q         <= x_d;
      y_q         <= y_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      c1x_q       <= c1x_d;
      c1y_q       <= c1y_d;
      c2x_q       <= c2x_d;
      c2y_q       <= c2y_d;
`ifdef LASER_FEEDER_SCORE_EN
      pt_q        <= pt_d;
      cover_q     <= cover_d;
`endif
    end
  end

  assign LRST      = lrst_q;
  assign X         = x_q;
  assign Y         = y_q;
  assign BUSY      = busy_q;
  assign RES_VALID = res_valid_q;
  assign RES_ERR   = res_err_q;
  assign RES_C1X   = c1x_q;
  assign RES_C1Y   = c1y_q;
  assign RES_C2X   = c2x_q;
  assign RES_C2Y   = c2y_q;

endmodule

// File: tb/tb_laser_feeder.sv
// tb_laser_feeder
//   Directed sequence with randomised point sets and centres. The expected
//   stream, centres, latencies and coverage come from a plain-arithmetic
//   model of the loaded point list kept in this bench.
module tb_laser_feeder;

  localparam int N   = 40;
  localparam int R   = 4;
  localparam int ERC = 2;
  localparam int TMO = 200;
`ifdef LASER_FEEDER_SCORE_EN
  localparam bit SCORE = 1'b1;
`else
  localparam bit SCORE = 1'b0;
`endif

  logic       clk, rst_n;
  logic       ld_valid, ld_ready, clr, start, lrst, done;
  logic [3:0] ld_x, ld_y, x, y, c1x, c1y, c2x, c2y;
  logic       busy, res_valid, res_err;
  logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
  logic [5:0] res_cover;

  laser_feeder #(.ITEM_NUM(N), .RADIUS(R), .ENG_RST_CYC(ERC), .TIMEOUT_CYC(TMO)) dut (
    .CLK(clk), .RST(rst_n), .LD_VALID(ld_valid), .LD_X(ld_x), .LD_Y(ld_y),
    .LD_READY(ld_ready), .CLR(clr), .START(start), .LRST(lrst), .X(x), .Y(y),
    .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y), .DONE(done), .BUSY(busy),
    .RES_VALID(res_valid), .RES_ERR(res_err), .RES_C1X(res_c1x),
    .RES_C1Y(res_c1y), .RES_C2X(res_c2x), .RES_C2Y(res_c2y), .RES_COVER(res_cover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int px[N];
  int py[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Coverage as a host would compute it from the point list and centres.
  function automatic int model_cover(input int ax, input int ay, input int bx, input int by);
    int n = 0;
    if (!SCORE) return 0;
    for (int i = 0; i < N; i++) begin
      if ((px[i]-ax)*(px[i]-ax) + (py[i]-ay)*(py[i]-ay) <= R*R ||
          (px[i]-bx)*(px[i]-bx) + (py[i]-by)*(py[i]-by) <= R*R) n++;
    end
    return n;
  endfunction

  task automatic load_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_x = 4'(px[i]); ld_y = 4'(py[i]);
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic clear_buf();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic rand_points();
    for (int i = 0; i < N; i++) begin
      px[i] = int'($urandom_range(15, 0));
      py[i] = int'($urandom_range(15, 0));
    end
  endtask

  task automatic do_run(input int ax, input int ay, input int bx, input int by,
                        input int exp_cover, input bit give_done, input bit stray_done);
    int lat;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("lrst_cyc1", lrst, 1);
    chk("busy_run", busy, 1);
    @(negedge clk);
    chk("lrst_cyc2", lrst, 1);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      done = stray_done && (k == 10);
      if (done) begin
        c1x = 4'($urandom); c1y = 4'($urandom); c2x = 4'($urandom); c2y = 4'($urandom);
      end
      if (k == 0) chk("lrst_release", lrst, 0);
      chk($sformatf("stream%0d", k), {24'd0, x, y}, 32'((px[k] << 4) | py[k]));
    end
    @(negedge clk);
    done = 1'b0;
    if (give_done) begin
      repeat ($urandom_range(4, 0)) @(negedge clk);
      c1x = 4'(ax); c1y = 4'(ay); c2x = 4'(bx); c2y = 4'(by); done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      c1x = 4'($urandom); c1y = 4'($urandom); c2x = 4'($urandom); c2y = 4'($urandom);
      chk("centres_at_done", {res_c1x, res_c1y, res_c2x, res_c2y},
          {4'(ax), 4'(ay), 4'(bx), 4'(by)});
      lat = 1;
      while (res_valid !== 1'b1 && lat < 200) begin
        @(negedge clk); lat++;
      end
      chk("res_latency", lat, SCORE ? N + 1 : 1);
      chk("res_err", res_err, 0);
      chk("res_cover", res_cover, exp_cover);
      chk("centres_held", {res_c1x, res_c1y, res_c2x, res_c2y},
          {4'(ax), 4'(ay), 4'(bx), 4'(by)});
    end else begin
      lat = 0;
      while (res_valid !== 1'b1 && lat < TMO + 50) begin
        @(negedge clk); lat++;
      end
      chk("tmo_latency", lat, TMO);
      chk("tmo_err", res_err, 1);
      chk("tmo_cover", res_cover, 0);
      chk("tmo_lrst", lrst, 1);
    end
    @(negedge clk);
    chk("res_pulse_end", res_valid, 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_x = '0; ld_y = '0; clr = 1'b0; start = 1'b0;
    done = 1'b0; c1x = '0; c1y = '0; c2x = '0; c2y = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_lrst", lrst, 1);
    chk("rst_xy", {x, y}, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_res", {res_valid, res_err, res_c1x, res_c1y, res_c2x, res_c2y, res_cover}, 0);
    rst_n = 1'b1;

    // All points at (5,5), C1 on top of them.
    for (int i = 0; i < N; i++) begin px[i] = 5; py[i] = 5; end
    load_range(0, N - 1);
    chk("full_ld_ready", ld_ready, 0);
    do_run(5, 5, 0, 0, SCORE ? 40 : 0, 1'b1, 1'b0);

    // Same buffer reruns without reloading; centres random.
    begin
      int ax = int'($urandom_range(15, 0)), ay = int'($urandom_range(15, 0));
      int bx = int'($urandom_range(15, 0)), by = int'($urandom_range(15, 0));
      do_run(ax, ay, bx, by, model_cover(ax, ay, bx, by), 1'b1, 1'b0);
    end

    // CLR colliding with a load drops the point; then two clusters.
    @(negedge clk); clr = 1'b1; ld_valid = 1'b1; ld_x = 4'd9; ld_y = 4'd9;
    @(negedge clk); clr = 1'b0; ld_valid = 1'b0;
    chk("clr_ld_ready", ld_ready, 1);
    for (int i = 0; i < N; i++) begin
      px[i] = (i < 20) ? 2 : 13; py[i] = (i < 20) ? 2 : 13;
    end
    load_range(0, N - 1);
    do_run(2, 2, 13, 13, SCORE ? 40 : 0, 1'b1, 1'b0);

    // Boundary: (12,8) and (8,4) sit exactly on radius 4; (11,11) is at 18.
    for (int i = 0; i < N; i++) begin
      px[i] = (i % 3 == 0) ? 12 : (i % 3 == 1) ? 8 : 11;
      py[i] = (i % 3 == 0) ? 8  : (i % 3 == 1) ? 4 : 11;
    end
    clear_buf();
    load_range(0, N - 1);
    do_run(8, 8, 8, 8, SCORE ? 27 : 0, 1'b1, 1'b0);

    // START with 39 points is ignored; the 40th point makes it valid.
    rand_points();
    clear_buf();
    load_range(0, N - 2);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start39_busy_a", busy, 0);
    @(negedge clk);
    chk("start39_busy_b", busy, 0);
    chk("start39_ld_ready", ld_ready, 1);
    load_range(N - 1, N - 1);
    chk("full40_ld_ready", ld_ready, 0);
    begin
      int ax = int'($urandom_range(15, 0)), ay = int'($urandom_range(15, 0));
      int bx = int'($urandom_range(15, 0)), by = int'($urandom_range(15, 0));
      do_run(ax, ay, bx, by, model_cover(ax, ay, bx, by), 1'b1, 1'b1);
    end

    // Random sets with centres drawn from the set itself.
    for (int r = 0; r < 2; r++) begin
      int a, b;
      rand_points();
      clear_buf();
      load_range(0, N - 1);
      a = int'($urandom_range(N - 1, 0));
      b = int'($urandom_range(N - 1, 0));
      do_run(px[a], py[a], px[b], py[b], model_cover(px[a], py[a], px[b], py[b]),
             1'b1, 1'b0);
    end

    // Engine never answers.
    do_run(0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Reset during stream cycle 17.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    repeat (17) @(negedge clk);
    chk("stream17_pre_rst", {24'd0, x, y}, 32'((px[17] << 4) | py[17]));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_lrst", lrst, 1);
    chk("midrst_xy", {x, y}, 0);
    chk("midrst_ld_ready", ld_ready, 1);
    chk("midrst_res", {res_c1x, res_c1y, res_c2x, res_c2y}, 0);
    rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("post_rst_start_busy", busy, 0);
    @(negedge clk);
    chk("post_rst_start_lrst", lrst, 1);
    rand_points();
    load_range(0, N - 1);
    begin
      int ax = int'($urandom_range(15, 0)), ay = int'($urandom_range(15, 0));
      do_run(ax, ay, px[0], py[0], model_cover(ax, ay, px[0], py[0]), 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/laser_feeder.md
# laser_feeder

Host-side driver for the two-circle laser placement engine. It buffers the 40 target points from a loader interface and resets the engine. It then streams the points on the engine's `X`/`Y` inputs, one per cycle, in the engine's fixed input order, waits for the engine's one-cycle `DONE`, and captures both circle centres. Optionally it scores the result by counting covered points. It is the producer/consumer counterpart of the engine's receive port and result port.

## Interface
- `ITEM_NUM`, 40, points per run (index counter 6 bits)
- `RADIUS`, 4, circle radius used for scoring
- `ENG_RST_CYC`, 2, cycles `LRST` is held high per run (≥1)
- `TIMEOUT_CYC`, 65535, max cycles waited for `DONE` (counter 17 bits)

Ports (reset is asynchronous and active-low):
- `CLK` in 1: single clock
- `RST` in 1: asynchronous, active-low reset
- `LD_VALID` in 1: loader point valid
- `LD_X`, `LD_Y` in 4 each: loader point coordinates
- `LD_READY` out 1: buffer accepts a point
- `CLR` in 1: empty the point buffer; honoured only in `IDLE`
- `START` in 1: begin a run; honoured only in `IDLE` with the buffer full
- `LRST` out 1: synchronous active-high reset to the engine
- `X`, `Y` out 4 each: point stream to the engine
- `C1X`, `C1Y`, `C2X`, `C2Y` in 4 each: engine result
- `DONE` in 1: engine result valid (single-cycle pulse)
- `BUSY` out 1: run in progress
- `RES_VALID` out 1: one-cycle result pulse
- `RES_ERR` out 1: timeout flag, qualified by `RES_VALID`
- `RES_C1X`, `RES_C1Y`, `RES_C2X`, `RES_C2Y` out 4 each: captured centres, held until the next run
- `RES_COVER` out 6: covered-point count, held until the next run

## Operation
The FSM has states `IDLE`, `ENG_RST`, `STREAM`, `WAIT`, `SCORE`, `REPORT`.

**IDLE**
- `LD_READY` = (count < `ITEM_NUM`).
- Each `LD_VALID & LD_READY` writes `buf[count]` and increments count.
- `CLR` sets count to 0. If `CLR` and `LD_VALID` occur in the same cycle, `CLR` wins and the point is dropped.
- `START` with count == `ITEM_NUM` moves to `ENG_RST`. Otherwise `START` is ignored.

**ENG_RST**
- `LRST` = 1 for `ENG_RST_CYC` cycles, then the FSM moves to `STREAM`.

**STREAM**
- `LRST` = 0. `X`/`Y` = `buf[k]` in the k-th `STREAM` cycle, k = 0..`ITEM_NUM`-1.
- Point 0 is driven in the same cycle `LRST` first reads 0.
- After the last point the FSM moves to `WAIT`.

**WAIT**
- Timeout counter runs from 0.
- On `DONE`: capture `C1X`..`C2Y` into `RES_*` and go to `SCORE`.
- When the counter reaches `TIMEOUT_CYC` with no `DONE`: set `RES_ERR` = 1, `RES_COVER` = 0, drive `LRST` = 1, and go to `REPORT`.

**SCORE**
- Scans `buf[0..ITEM_NUM-1]`, one point per cycle.
- dx, dy are 5-bit signed differences. A point is covered if dx²+dy² ≤ `RADIUS`² (9-bit unsigned compare) against C1 or against C2.
- The count accumulates into `RES_COVER`. After `ITEM_NUM` cycles the FSM moves to `REPORT`.

**REPORT**
- `RES_VALID` = 1 for one cycle, then the FSM returns to `IDLE`.
- The buffer is retained, so a new `START` reruns the same set.

Common rules:
- `BUSY` = 1 in every state except `IDLE`.
- `DONE` outside `WAIT` is ignored.
- `LD_VALID`, `CLR` and `START` outside `IDLE` are ignored.

## Timing
- Reset values:
  - state `IDLE`, count 0
  - `LRST` = 1 (engine held in reset)
  - `X` = `Y` = 0
  - `LD_READY` = 1
  - `BUSY` = 0
  - all `RES_*` = 0
- All outputs are registered except `LD_READY`, which is decoded from state and count.
- `START` accepted at edge t: `LRST` is high during cycles t+1..t+`ENG_RST_CYC`. Point k is on `X`/`Y` in cycle t+`ENG_RST_CYC`+1+k.
- `DONE` sampled at edge d: `RES_*` centres are updated at d.
- `RES_VALID`:
  - with scoring: at cycle d+`ITEM_NUM`+1
  - without scoring: at d+1
  - on timeout: one cycle after the timeout
- Asserting `RST` mid-run returns the block to reset values immediately, including count 0. Buffer contents are not cleared but are unreachable until reloaded.

## Configuration
- Macro `LASER_FEEDER_SCORE_EN`.
  - Defined: the `SCORE` state and coverage datapath are built.
  - Undefined: `WAIT` goes directly to `REPORT` and `RES_COVER` is tied to 0.
- Stream and result timing are otherwise identical in both builds.

## Test plan
- All 40 points = (5,5); engine model returns C1 = (5,5), C2 = (0,0) → `RES_VALID` pulse, `RES_C1X/Y` = 5/5, `RES_COVER` = 40, `RES_ERR` = 0.
- Points 0..19 = (2,2), points 20..39 = (13,13); engine returns C1 = (2,2), C2 = (13,13) → `RES_COVER` = 40. Stream order checked: `X`/`Y` in stream cycle k equals `buf[k]`.
- Boundary scoring with C1 = C2 = (8,8):
  - points at (12,8) and (8,4) are counted
  - a point at (11,11) (distance² = 18) is not counted
  - `RES_COVER` = count of the boundary-inside points only
- `START` with 39 points loaded → ignored, `BUSY` stays 0. Load the 40th point and `START` again → `LRST` high for exactly 2 cycles, then 40 stream cycles.
- Engine model never pulses `DONE` → after `TIMEOUT_CYC` cycles in `WAIT`: `RES_VALID` = 1, `RES_ERR` = 1, `RES_COVER` = 0, `LRST` = 1.
- Assert `RST` at stream cycle 17 → next cycle `BUSY` = 0, `LRST` = 1, `X` = `Y` = 0, `LD_READY` = 1, and a subsequent `START` is ignored until 40 points are reloaded.
